// File: rtl/sweep_pkg.sv
// Shared types and constants for the minterm sweep checker and its settle timer.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } sweep_state_t;

   // Mask width for an n-input truth table.
   function automatic int mw(input int n);
      return 1 << n;
   endfunction

   // Truth table of the SoP function with minterms 1, 2, 5 and 6.
   localparam logic [7:0] SOP_1256_MASK = 8'b0110_0110;

endpackage

// File: rtl/sweep_settle_timer.sv
// Counts the cycles a vector has been held in DRIVE.
// Flags expire on the last of the SETTLE hold cycles.
module sweep_settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = count && (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/minterm_sweep_checker.sv
// Walks every input vector of an N_IN-input function and records its truth table.
// Compares the recorded table against EXP_MASK and reports the errors it finds.
module minterm_sweep_checker
   import sweep_pkg::*;
#(
   parameter int                   N_IN     = 3,
   parameter int                   SETTLE   = 1,
   parameter logic [mw(N_IN)-1:0]  EXP_MASK = SOP_1256_MASK
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                f_in,
   output logic [N_IN-1:0]     vec_out,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [mw(N_IN)-1:0] mask,
   output logic [N_IN:0]       err_cnt,
   output logic [N_IN-1:0]     first_err
);

   localparam int              MW   = mw(N_IN);
   localparam logic [N_IN-1:0] LAST = N_IN'(MW - 1);

   sweep_state_t    state;
   sweep_state_t    state_next;
   logic [N_IN-1:0] idx;
   logic            expire;
   logic            exp_bit;
   logic            mismatch;
   logic            f_one;

   sweep_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state != DRIVE),
      .count  (state == DRIVE),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = DRIVE;
         DRIVE:      if (expire) state_next = SAMPLE;
         SAMPLE:     state_next = (idx == LAST) ? DONE : DRIVE;
         default:    state_next = IDLE;
      endcase
   end

   // An unknown f_in is never a valid answer: it is recorded as 0 and always mismatches.
   assign exp_bit  = EXP_MASK[idx];
   assign mismatch = (f_in !== exp_bit);
   assign f_one    = (f_in === 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         mask      <= '0;
         err_cnt   <= '0;
         first_err <= '0;
         pass      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx       <= '0;
                  mask      <= '0;
                  err_cnt   <= '0;
                  first_err <= '0;
                  pass      <= 1'b0;
               end
            end
            SAMPLE: begin
               mask[idx] <= f_one;
               if (mismatch) begin
                  err_cnt <= err_cnt + 1'b1;
                  if (err_cnt == '0) first_err <= idx;
               end
               if (idx != LAST) begin
                  idx <= idx + 1'b1;
               end else begin
                  pass <= (err_cnt == '0) && !mismatch;
               end
            end
            default: ;
         endcase
         busy <= (state_next == DRIVE) || (state_next == SAMPLE);
         done <= (state_next == DONE);
      end
   end

   assign vec_out = idx;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench for minterm_sweep_checker: default build plus a SETTLE=3 build.
module tb_minterm_sweep_checker;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic       start3 = 1'b0;
   logic       f_in;
   logic       f_in3;
   int         fn_mode = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         cycles;

   logic [2:0] vec_out, vec3;
   logic       busy, done, pass, busy3, done3, pass3;
   logic [7:0] mask, mask3;
   logic [3:0] err_cnt, err_cnt3;
   logic [2:0] first_err, first_err3;

   minterm_sweep_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .f_in      (f_in),
      .vec_out   (vec_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .mask      (mask),
      .err_cnt   (err_cnt),
      .first_err (first_err)
   );

   minterm_sweep_checker #(
      .SETTLE (3)
   ) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start3),
      .f_in      (f_in3),
      .vec_out   (vec3),
      .busy      (busy3),
      .done      (done3),
      .pass      (pass3),
      .mask      (mask3),
      .err_cnt   (err_cnt3),
      .first_err (first_err3)
   );

   always #5 clk = ~clk;

   // Function under test: XOR of the two low inputs (minterms 1,2,5,6) or a faulty variant.
   always_comb begin
      f_in = vec_out[1] ^ vec_out[0];
      case (fn_mode)
         1:       f_in = 1'b0;
         2:       if (vec_out == 3'd5) f_in = 1'bx;
         default: ;
      endcase
   end

   assign f_in3 = vec3[1] ^ vec3[0];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed === expected) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   // Pulses start on the chosen instance and counts cycles from the start edge to done.
   task automatic applyStimulus(input int which, output int n_cyc);
      @(posedge clk); #1;
      if (which == 3) start3 = 1'b1;
      else            start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      start3 = 1'b0;
      n_cyc  = 0;
      checkOutput("busy_after_start", (which == 3) ? busy3 : busy, 1);
      checkOutput("done_cleared_on_start", (which == 3) ? done3 : done, 0);
      while (!((which == 3) ? done3 : done) && n_cyc < 200) begin
         @(posedge clk); #1;
         n_cyc++;
      end
   endtask

   task automatic checkSweep(input string tag, input logic [7:0] m, input logic [3:0] e,
                             input logic [2:0] fe, input logic p);
      $display("[TB] results for %s", tag);
      checkOutput("mask", mask, m);
      checkOutput("err_cnt", err_cnt, e);
      checkOutput("first_err", first_err, fe);
      checkOutput("pass", pass, p);
      checkOutput("busy_in_done", busy, 0);
      checkOutput("vec_held_last", vec_out, 7);
   endtask

   task automatic checkAllZero(input string tag);
      $display("[TB] zero-output check: %s", tag);
      checkOutput("zero_vec", vec_out, 0);
      checkOutput("zero_busy", busy, 0);
      checkOutput("zero_done", done, 0);
      checkOutput("zero_pass", pass, 0);
      checkOutput("zero_mask", mask, 0);
      checkOutput("zero_err_cnt", err_cnt, 0);
      checkOutput("zero_first_err", first_err, 0);
   endtask

   initial begin
      #2;
      checkAllZero("in reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkAllZero("after reset release");

      // Test 1: correct function.
      fn_mode = 0;
      applyStimulus(1, cycles);
      checkOutput("t1_latency", cycles, 16);
      checkSweep("t1 xor", 8'h66, 4'd0, 3'd0, 1'b1);

      // Test 2: stuck-at-0 function, restarted from DONE.
      fn_mode = 1;
      applyStimulus(1, cycles);
      checkOutput("t2_latency", cycles, 16);
      checkSweep("t2 stuck0", 8'h00, 4'd4, 3'd1, 1'b0);

      // Test 3: unknown output on vector 5 only.
      fn_mode = 2;
      applyStimulus(1, cycles);
      checkOutput("t3_latency", cycles, 16);
      checkSweep("t3 x on 5", 8'h46, 4'd1, 3'd5, 1'b0);

      // Test 4: start pulses while busy are ignored.
      fn_mode = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 16; c++) begin
         checkOutput("t4_vec_seq", vec_out, c / 2);
         if (c == 15) checkOutput("t4_not_done_early", done, 0);
         start = (c == 3 || c == 9);
         @(posedge clk); #1;
      end
      start = 1'b0;
      checkOutput("t4_done_at_16", done, 1);
      checkSweep("t4 extra starts", 8'h66, 4'd0, 3'd0, 1'b1);

      // Test 5: reset in the middle of a failing sweep.
      fn_mode = 1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
      end
      checkOutput("t5_err_before_reset", err_cnt, 2);
      rst_n = 1'b0;
      #1;
      checkAllZero("mid-sweep reset");
      @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      fn_mode = 0;
      applyStimulus(1, cycles);
      checkOutput("t5_latency", cycles, 16);
      checkSweep("t5 after reset", 8'h66, 4'd0, 3'd0, 1'b1);

      // Test 6: SETTLE=3 build holds each vector four cycles.
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      for (int c = 0; c < 32; c++) begin
         checkOutput("t6_vec_hold", vec3, c / 4);
         @(posedge clk); #1;
      end
      checkOutput("t6_done_at_32", done3, 1);
      checkOutput("t6_mask", mask3, 8'h66);
      checkOutput("t6_pass", pass3, 1);
      checkOutput("t6_err_cnt", err_cnt3, 0);
      applyStimulus(3, cycles);
      checkOutput("t6_restart_latency", cycles, 32);
      checkOutput("t6_restart_mask", mask3, 8'h66);
      checkOutput("t6_restart_pass", pass3, 1);
      checkOutput("t6_vec_held_last", vec3, 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
